// File: rtl/axi4_wr_slave.sv
// AXI4 write-channel slave: AW/W/B in, one registered memory write per beat.
// Define AXI4_WR_SLAVE_WRAP_EN to support WRAP bursts (otherwise rejected).
module axi4_wr_slave #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ID_W-1:0]     AWID,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [7:0]          AWLEN,
   input  logic [2:0]          AWSIZE,
   input  logic [1:0]          AWBURST,
   input  logic                AWLOCK,
   input  logic [3:0]          AWCACHE,
   input  logic [2:0]          AWPROT,
   input  logic [3:0]          AWQOS,
   input  logic [3:0]          AWREGION,
   input  logic                AWUSER,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WLAST,
   input  logic                WUSER,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [ID_W-1:0]     BID,
   output logic [1:0]          BRESP,
   output logic                BUSER,
   output logic                BVALID,
   input  logic                BREADY,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb
);

   localparam logic [2:0] SZ_MAX = 3'($clog2(DATA_W/8));

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        r_state;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len;
   logic [7:0]        r_cnt;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              r_rej;
   logic [ID_W-1:0]   r_bid;
   logic [1:0]        r_bresp;

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_b_hs;
   logic              w_rej;
   logic              w_last_cnt;
   logic              w_done;
   logic              w_err_end;
   logic [ADDR_W-1:0] w_beat;
   logic [ADDR_W-1:0] w_incr;
   logic [ADDR_W-1:0] w_next;
   logic              w_unused;

   assign AWREADY = (r_state == S_IDLE) & ~ARESET;
   assign WREADY  = (r_state == S_DATA);
   assign BVALID  = (r_state == S_RESP);
   assign BID     = r_bid;
   assign BRESP   = r_bresp;
   assign BUSER   = 1'b0;

   assign w_aw_hs = AWVALID & AWREADY;
   assign w_w_hs  = WVALID & WREADY;
   assign w_b_hs  = BVALID & BREADY;

   assign w_unused = ^{AWLOCK, AWCACHE, AWPROT,
                       AWQOS, AWREGION, AWUSER, WUSER};

   always_comb begin
      w_rej = (AWSIZE > SZ_MAX) | (AWBURST == 2'b11);
`ifdef AXI4_WR_SLAVE_WRAP_EN
      if (AWBURST == 2'b10)
         w_rej = w_rej | ~((AWLEN == 8'd1) | (AWLEN == 8'd3) |
                           (AWLEN == 8'd7) | (AWLEN == 8'd15));
`else
      if (AWBURST == 2'b10)
         w_rej = 1'b1;
`endif
   end

   assign w_beat = ADDR_W'(1) << r_size;
   assign w_incr = (r_addr & ~(w_beat - ADDR_W'(1))) + w_beat;

`ifdef AXI4_WR_SLAVE_WRAP_EN
   logic [2:0]        w_wlog;
   logic [ADDR_W-1:0] w_mask;

   always_comb begin
      case (r_len[3:0])
         4'd1:    w_wlog = 3'd1;
         4'd3:    w_wlog = 3'd2;
         4'd7:    w_wlog = 3'd3;
         default: w_wlog = 3'd4;
      endcase
   end

   // container is a power of two, so wrapping is base | offset
   assign w_mask = (w_beat << w_wlog) - ADDR_W'(1);
`endif

   always_comb begin
      w_next = r_addr;
      case (r_burst)
         2'b01:   w_next = w_incr;
`ifdef AXI4_WR_SLAVE_WRAP_EN
         2'b10:   w_next = (r_addr & ~w_mask) | (w_incr & w_mask);
`endif
         default: w_next = r_addr;
      endcase
   end

   assign w_last_cnt = (r_cnt == r_len);
   assign w_done     = w_last_cnt | WLAST;
   assign w_err_end  = r_rej | (w_last_cnt != WLAST);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= S_IDLE;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_rej     <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= 2'b00;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_aw_hs) begin
                  r_state <= S_DATA;
                  r_id    <= AWID;
                  r_addr  <= AWADDR;
                  r_len   <= AWLEN;
                  r_size  <= AWSIZE;
                  r_burst <= AWBURST;
                  r_cnt   <= 8'd0;
                  r_rej   <= w_rej;
               end
            end
            S_DATA: begin
               if (w_w_hs) begin
                  if (!r_rej) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= r_addr;
                     mem_wdata <= WDATA;
                     mem_wstrb <= WSTRB;
                  end
                  r_addr <= w_next;
                  r_cnt  <= r_cnt + 8'd1;
                  if (w_done) begin
                     r_state <= S_RESP;
                     r_bid   <= r_id;
                     r_bresp <= w_err_end ? 2'b10 : 2'b00;
                  end
               end
            end
            S_RESP: begin
               if (w_b_hs)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
